// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the 6502-class pin-side bus bridge.
package cpu_bus_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} bus_state_e;

    localparam logic [7:0] BUS_ERR_DATA = 8'hFF;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/cpu_bus_bridge_if.sv
// Core-side and pin-side handshake signals of the bus bridge.
interface cpu_bus_bridge_if import cpu_bus_pkg::*; #(
    parameter int ADDR_W = 16,
    parameter int PIN_W  = 8
) ();
    localparam int ADDR_PH = ceil_div(ADDR_W, PIN_W);

    logic              core_req;
    logic [ADDR_W-1:0] core_ab;
    logic [7:0]        core_do;
    logic              core_we;
    logic [7:0]        core_di;
    logic              core_rdy;
    logic [PIN_W-1:0]  io_in;
    logic [PIN_W-1:0]  io_out;
    logic              io_oeb;
    logic [ADDR_PH-1:0] ale;
    logic              rd_n;
    logic              wr_n;
    logic              wait_in;

    // bridge side
    modport slave (
        input  core_req, core_ab, core_do, core_we, io_in, wait_in,
        output core_di, core_rdy, io_out, io_oeb, ale, rd_n, wr_n
    );

    // core + pin environment side
    modport master (
        output core_req, core_ab, core_do, core_we, io_in, wait_in,
        input  core_di, core_rdy, io_out, io_oeb, ale, rd_n, wr_n
    );

endinterface

// File: rtl/cpu_bus_bridge_sync_chain.sv
// Multi-flop level synchroniser that resets to 1 (inactive for active-low pins).
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[DEPTH-2:0], d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/cpu_bus_bridge.sv
// Multiplexes core address/data over a narrow pin bus with ALE strobes,
// wait states, transfer timeout and synchronised interrupt pins.
module cpu_bus_bridge import cpu_bus_pkg::*; #(
    parameter int ADDR_W      = 16,
    parameter int PIN_W       = 8,
    parameter int WAIT_STATES = 0,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic clk,
    input  logic rst_n,
    cpu_bus_bridge_if.slave bus,
    input  logic irq_pin_n,
    input  logic nmi_pin_n,
    input  logic err_clr,
    output logic core_irq_n,
    output logic core_nmi_n,
    output logic bus_err
);
    localparam int ADDR_PH = ceil_div(ADDR_W, PIN_W);
    localparam int PH_W    = (clog2(ADDR_PH) > 0) ? clog2(ADDR_PH) : 1;
    localparam int AX_W    = ADDR_PH * PIN_W;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(ADDR_PH - 1);

    bus_state_e         state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic [15:0]        tcnt_q, tcnt_d;
    logic [PIN_W-1:0]   io_out_q, io_out_d;
    logic               io_oeb_q, io_oeb_d;
    logic [ADDR_PH-1:0] ale_q, ale_d;
    logic               rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic               rdy_q, rdy_d;
    logic [7:0]         di_q, di_d;
    logic               err_q, err_d;
    logic               drive_data, tmo_evt;

    // Zero-extend the address to whole chunks, then pick chunk k.
    function automatic logic [PIN_W-1:0] chunk(input logic [ADDR_W-1:0] a, input int k);
        logic [AX_W-1:0] ax;
        ax = '0;
        ax[ADDR_W-1:0] = a;
        return ax[k*PIN_W +: PIN_W];
    endfunction

    always_comb begin
        state_d = state_q;  phase_d = phase_q;  addr_d = addr_q;
        wdata_d = wdata_q;  we_d = we_q;        wcnt_d = wcnt_q;
        tcnt_d  = tcnt_q;   di_d = di_q;
        io_out_d = '0;  io_oeb_d = 1'b1;  ale_d = '0;
        rd_n_d = 1'b1;  wr_n_d = 1'b1;    rdy_d = 1'b0;
        drive_data = 1'b0;  tmo_evt = 1'b0;
        case (state_q)
            S_IDLE: if (bus.core_req) begin
                addr_d   = bus.core_ab;
                wdata_d  = bus.core_do;
                we_d     = bus.core_we;
                phase_d  = '0;
                state_d  = S_ADDR;
                io_out_d = chunk(bus.core_ab, 0);
                ale_d    = ADDR_PH'(1);
                io_oeb_d = 1'b0;
            end
            S_ADDR: if (phase_q == LAST_PH) begin
                state_d    = S_DATA;
                wcnt_d     = 4'(WAIT_STATES);
                tcnt_d     = '0;
                drive_data = 1'b1;
            end else begin
                phase_d  = phase_q + 1'b1;
                io_out_d = chunk(addr_q, int'(phase_d));
                ale_d    = ADDR_PH'(1) << phase_d;
                io_oeb_d = 1'b0;
            end
            S_DATA: begin
                // A normal completion takes precedence over a timeout landing on the same cycle.
                if (wcnt_q == 4'd0 && !bus.wait_in) begin
                    state_d = S_DONE;
                    rdy_d   = 1'b1;
                    if (!we_q) di_d = bus.io_in[7:0];
                end else if (TIMEOUT != 0 && ({16'd0, tcnt_q} + 32'd1) == 32'(TIMEOUT)) begin
                    state_d = S_DONE;
                    rdy_d   = 1'b1;
                    di_d    = BUS_ERR_DATA;
                    tmo_evt = 1'b1;
                end else begin
                    wcnt_d     = (wcnt_q == 4'd0) ? 4'd0 : wcnt_q - 4'd1;
                    tcnt_d     = tcnt_q + 16'd1;
                    drive_data = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (drive_data) begin
            io_out_d = we_q ? PIN_W'(wdata_q) : '0;
            io_oeb_d = !we_q;
            wr_n_d   = !we_q;
            rd_n_d   = we_q;
        end
        err_d = tmo_evt ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;  phase_q <= '0;  addr_q <= '0;  wdata_q <= '0;
            we_q <= 1'b0;  wcnt_q <= '0;  tcnt_q <= '0;
            io_out_q <= '0;  io_oeb_q <= 1'b1;  ale_q <= '0;
            rd_n_q <= 1'b1;  wr_n_q <= 1'b1;  rdy_q <= 1'b0;
            di_q <= '0;  err_q <= 1'b0;
        end else begin
            state_q <= state_d;  phase_q <= phase_d;  addr_q <= addr_d;  wdata_q <= wdata_d;
            we_q <= we_d;  wcnt_q <= wcnt_d;  tcnt_q <= tcnt_d;
            io_out_q <= io_out_d;  io_oeb_q <= io_oeb_d;  ale_q <= ale_d;
            rd_n_q <= rd_n_d;  wr_n_q <= wr_n_d;  rdy_q <= rdy_d;
            di_q <= di_d;  err_q <= err_d;
        end
    end

    assign bus.io_out   = io_out_q;
    assign bus.io_oeb   = io_oeb_q;
    assign bus.ale      = ale_q;
    assign bus.rd_n     = rd_n_q;
    assign bus.wr_n     = wr_n_q;
    assign bus.core_rdy = rdy_q;
    assign bus.core_di  = di_q;
    assign bus_err      = err_q;

    sync_chain #(.DEPTH(SYNC_STAGES)) u_irq_sync (.clk(clk), .rst_n(rst_n), .d(irq_pin_n), .q(core_irq_n));
    sync_chain #(.DEPTH(SYNC_STAGES)) u_nmi_sync (.clk(clk), .rst_n(rst_n), .d(nmi_pin_n), .q(core_nmi_n));

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Bench for cpu_bus_bridge: instance 0 uses defaults, instance 1 uses
// WAIT_STATES=2 / TIMEOUT=4; expectations come from a transfer-level model.
module tb_cpu_bus_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req [2], we [2], wt [2], clr [2];
    logic [15:0] ab [2];
    logic [7:0]  dout [2], ioin [2];
    logic        irq_pin = 1'b1, nmi_pin = 1'b1;

    wire [7:0] di [2], ioout [2];
    wire [1:0] ale [2];
    wire       rdy [2], oeb [2], rdn [2], wrn [2], berr [2], irqn [2], nmin [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_bus_bridge_if #(.ADDR_W(16), .PIN_W(8)) bus ();
        assign bus.core_req = req[g];
        assign bus.core_ab  = ab[g];
        assign bus.core_do  = dout[g];
        assign bus.core_we  = we[g];
        assign bus.io_in    = ioin[g];
        assign bus.wait_in  = wt[g];
        assign di[g]    = bus.core_di;
        assign rdy[g]   = bus.core_rdy;
        assign ioout[g] = bus.io_out;
        assign oeb[g]   = bus.io_oeb;
        assign ale[g]   = bus.ale;
        assign rdn[g]   = bus.rd_n;
        assign wrn[g]   = bus.wr_n;
        cpu_bus_bridge #(.ADDR_W(16), .PIN_W(8), .WAIT_STATES(g == 1 ? 2 : 0),
                         .SYNC_STAGES(2), .TIMEOUT(g == 1 ? 4 : 255)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus),
            .irq_pin_n(irq_pin), .nmi_pin_n(nmi_pin), .err_clr(clr[g]),
            .core_irq_n(irqn[g]), .core_nmi_n(nmin[g]), .bus_err(berr[g]));
    end

    int npass = 0, ntot = 0;
    int ws [2] = '{0, 2};
    int to [2] = '{255, 4};
    logic [7:0] m_di [2];
    logic       m_err [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_reset(input int d);
        chk("rst_io_out", ioout[d], 0);  chk("rst_oeb", oeb[d], 1);
        chk("rst_ale", ale[d], 0);       chk("rst_rd_n", rdn[d], 1);
        chk("rst_wr_n", wrn[d], 1);      chk("rst_rdy", rdy[d], 0);
        chk("rst_di", di[d], 0);         chk("rst_bus_err", berr[d], 0);
        chk("rst_irq_n", irqn[d], 1);    chk("rst_nmi_n", nmin[d], 1);
    endtask

    // One transfer, entered and left at a negedge in IDLE. DATA lasts until the
    // first cycle past both the programmed and external waits, capped by TIMEOUT.
    task automatic xfer(input int d, input logic [15:0] a, input logic [7:0] wd, input logic w,
                        input int ext, input logic [7:0] rdv, input bit keep, input bit clr_last);
        int n_leave, n;
        bit tmo;
        n_leave = ((ws[d] > ext) ? ws[d] : ext) + 1;
        tmo = (to[d] != 0) && (to[d] < n_leave);
        n = tmo ? to[d] : n_leave;
        req[d] = 1'b1; ab[d] = a; dout[d] = wd; we[d] = w; wt[d] = 1'b0;
        @(negedge clk);
        if (!keep) req[d] = 1'b0;
        ab[d] = ~a; dout[d] = ~wd; we[d] = ~w;
        chk("addr0_io", ioout[d], a[7:0]);  chk("addr0_ale", ale[d], 2'b01);
        chk("addr0_oeb", oeb[d], 0);        chk("addr0_rdy", rdy[d], 0);
        @(negedge clk);
        chk("addr1_io", ioout[d], a[15:8]); chk("addr1_ale", ale[d], 2'b10);
        chk("addr1_oeb", oeb[d], 0);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            wt[d] = (i <= ext); ioin[d] = rdv; clr[d] = clr_last && (i == n);
            chk("data_rd_n", rdn[d], w);   chk("data_wr_n", wrn[d], !w);
            chk("data_oeb", oeb[d], !w);   chk("data_ale", ale[d], 0);
            chk("data_rdy", rdy[d], 0);
            if (w) chk("data_io", ioout[d], wd);
        end
        @(negedge clk);
        wt[d] = 1'b0; clr[d] = 1'b0;
        if (tmo) begin m_di[d] = 8'hFF; m_err[d] = 1'b1; end
        else if (!w) m_di[d] = rdv;
        chk("done_rdy", rdy[d], 1);      chk("done_di", di[d], m_di[d]);
        chk("done_bus_err", berr[d], m_err[d]);
        chk("done_rd_n", rdn[d], 1);     chk("done_wr_n", wrn[d], 1);
        chk("done_oeb", oeb[d], 1);      chk("done_ale", ale[d], 0);
        @(negedge clk);
        chk("idle_rdy", rdy[d], 0);      chk("idle_ale", ale[d], 0);
        chk("idle_oeb", oeb[d], 1);      chk("idle_di", di[d], m_di[d]);
    endtask

    task automatic err_clear(input int d);
        clr[d] = 1'b1;
        @(negedge clk);
        clr[d] = 1'b0; m_err[d] = 1'b0;
        chk("err_clr", berr[d], 0);
    endtask

    task automatic sync_test(input bit nmi);
        if (nmi) nmi_pin = 1'b0; else irq_pin = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("sync_fall1", nmi ? nmin[d] : irqn[d], 1);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("sync_fall2", nmi ? nmin[d] : irqn[d], 0);
        if (nmi) nmi_pin = 1'b1; else irq_pin = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("sync_hold", nmi ? nmin[d] : irqn[d], 0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("sync_rise", nmi ? nmin[d] : irqn[d], 1);
        // single-cycle pulse
        if (nmi) nmi_pin = 1'b0; else irq_pin = 1'b0;
        @(negedge clk);
        if (nmi) nmi_pin = 1'b1; else irq_pin = 1'b1;
        for (int d = 0; d < 2; d++) chk("pulse_pre", nmi ? nmin[d] : irqn[d], 1);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("pulse_low", nmi ? nmin[d] : irqn[d], 0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("pulse_end", nmi ? nmin[d] : irqn[d], 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; we[d] = 0; wt[d] = 0; clr[d] = 0; ab[d] = 0; dout[d] = 0; ioin[d] = 0;
            m_di[d] = 0; m_err[d] = 0;
        end
        repeat (2) @(negedge clk);
        chk_reset(0); chk_reset(1);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(0, 16'hBEEF, 8'h00, 1'b0, 0, 8'h5A, 1'b0, 1'b0);
        xfer(1, 16'h1234, 8'hC3, 1'b1, 0, 8'h00, 1'b0, 1'b0);
        xfer(0, 16'h0042, 8'h00, 1'b0, 5, 8'h96, 1'b0, 1'b0);
        xfer(1, 16'hA5A5, 8'h11, 1'b1, 20, 8'h00, 1'b0, 1'b0);
        err_clear(1);
        xfer(1, 16'h5A5A, 8'h00, 1'b0, 9, 8'h33, 1'b0, 1'b1);
        err_clear(1);

        // back-to-back with core_req held high
        xfer(0, 16'h1111, 8'hAA, 1'b1, 0, 8'h00, 1'b1, 1'b0);
        xfer(0, 16'h2222, 8'h00, 1'b0, 1, 8'h77, 1'b1, 1'b0);
        req[0] = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            int d, ext;
            d = int'($urandom_range(0, 1));
            ext = int'($urandom_range(0, 6));
            if (d == 1 && ext == 3) ext = 6;
            xfer(d, 16'($urandom), 8'($urandom), 1'($urandom), ext, 8'($urandom), 1'b0, 1'b0);
        end
        err_clear(1);

        // asynchronous reset during a write DATA phase
        req[0] = 1'b1; ab[0] = 16'hCAFE; dout[0] = 8'h3C; we[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        wt[0] = 1'b1;
        @(negedge clk);
        chk("pre_rst_wr_n", wrn[0], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_wr_n", wrn[0], 1);  chk("async_oeb", oeb[0], 1);
        chk("async_rdy", rdy[0], 0);   chk("async_ale", ale[0], 0);
        @(negedge clk);
        rst_n = 1'b1; wt[0] = 1'b0;
        for (int d = 0; d < 2; d++) begin m_di[d] = 0; m_err[d] = 0; end
        @(negedge clk);
        chk("post_rst_ale", ale[0], 0); chk("post_rst_oeb", oeb[0], 1);
        xfer(0, 16'h0F0F, 8'h00, 1'b0, 0, 8'hE1, 1'b0, 1'b0);

        sync_test(1'b0);
        sync_test(1'b1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
